// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU control FSM: sequences each instruction through
// IF/ID/EXE/MEM/WB and drives the PC, IR, register-file and data-memory strobes.
// Optional build macro MEM_WAIT_EN adds the mem_ready port and lets MEM stall
// until the data memory reports completion.
// Handshake: with MEM_WAIT_EN, mem_rd/mem_wr act as request valids held high in
// MEM; mem_ready is the memory's ready, and the transfer completes (MEM exits)
// on the rising edge where mem_ready=1.
module multicycle_ctrl #(
  parameter int              OP_W    = 6,
  parameter logic [OP_W-1:0] HALT_OP = '1
) (
  input  logic            click,
  input  logic            reset,
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
`ifdef MEM_WAIT_EN
  input  logic            mem_ready,
`endif
  output logic            PCWre,
  output logic [1:0]      pc_src,
  output logic            IRWre,
  output logic            RegWre,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic [2:0]      state,
  output logic            halted
);

  localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b000001);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b110000);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b110001);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b110100);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b111000);

  localparam logic [2:0] S_IF   = 3'b000;
  localparam logic [2:0] S_ID   = 3'b001;
  localparam logic [2:0] S_EXE  = 3'b010;
  localparam logic [2:0] S_MEM  = 3'b011;
  localparam logic [2:0] S_WB   = 3'b100;
  localparam logic [2:0] S_HALT = 3'b111;

  typedef enum logic [2:0] {
    K_ALU, K_LW, K_SW, K_BEQ, K_J, K_HALT, K_NOP
  } kind_t;

  logic [2:0] state_q;
  logic [2:0] state_d;
  kind_t      kind;
  logic       mem_go;

`ifdef MEM_WAIT_EN
  assign mem_go = mem_ready;
`else
  assign mem_go = 1'b1;
`endif

  // Instruction class decode; HALT_OP is checked first so it wins any overlap.
  always_comb begin
    kind = K_NOP;
    if (opcode == HALT_OP)                         kind = K_HALT;
    else if (opcode == OP_R || opcode == OP_ADDI)  kind = K_ALU;
    else if (opcode == OP_LW)                      kind = K_LW;
    else if (opcode == OP_SW)                      kind = K_SW;
    else if (opcode == OP_BEQ)                     kind = K_BEQ;
    else if (opcode == OP_J)                       kind = K_J;
  end

  // State register; reset low returns to IF immediately.
  always_ff @(posedge click or negedge reset) begin
    if (!reset) state_q <= S_IF;
    else        state_q <= state_d;
  end

  // Next-state: per-class path through the stages; unused codes fall back to IF.
  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF:   state_d = S_ID;
      S_ID: begin
        case (kind)
          K_ALU, K_LW, K_SW, K_BEQ: state_d = S_EXE;
          K_HALT:                   state_d = S_HALT;
          default:                  state_d = S_IF;
        endcase
      end
      S_EXE: begin
        case (kind)
          K_LW, K_SW: state_d = S_MEM;
          K_ALU:      state_d = S_WB;
          default:    state_d = S_IF;
        endcase
      end
      S_MEM: begin
        if (!mem_go)           state_d = S_MEM;
        else if (kind == K_LW) state_d = S_WB;
        else                   state_d = S_IF;
      end
      S_WB:   state_d = S_IF;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  // Outputs: decoded from state/opcode/zero, forced quiet while reset is low.
  always_comb begin
    PCWre  = 1'b0;
    pc_src = 2'b00;
    IRWre  = 1'b0;
    RegWre = 1'b0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    halted = 1'b0;
    if (reset) begin
      case (state_q)
        S_IF: IRWre = 1'b1;
        S_ID: begin
          if (kind == K_J) begin
            PCWre  = 1'b1;
            pc_src = 2'b10;
          end else if (kind == K_NOP) begin
            PCWre = 1'b1;
          end
        end
        S_EXE: begin
          if (kind == K_BEQ) begin
            PCWre  = 1'b1;
            pc_src = zero ? 2'b01 : 2'b00;
          end
        end
        S_MEM: begin
          if (kind == K_LW) begin
            mem_rd = 1'b1;
          end else if (kind == K_SW) begin
            mem_wr = 1'b1;
            PCWre  = mem_go;
          end
        end
        S_WB: begin
          RegWre = 1'b1;
          PCWre  = 1'b1;
        end
        S_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: randomized instruction stream checked cycle by
// cycle against a stage-path reference model through an expected-value queue.
module tb_multicycle_ctrl;

  logic       click;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       PCWre;
  logic [1:0] pc_src;
  logic       IRWre;
  logic       RegWre;
  logic       mem_rd;
  logic       mem_wr;
  logic [2:0] state;
  logic       halted;

  multicycle_ctrl #(.OP_W(6), .HALT_OP(6'b111111)) dut (
    .click     (click),
    .reset     (reset),
    .opcode    (opcode),
    .zero      (zero),
`ifdef MEM_WAIT_EN
    .mem_ready (mem_ready),
`endif
    .PCWre     (PCWre),
    .pc_src    (pc_src),
    .IRWre     (IRWre),
    .RegWre    (RegWre),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .state     (state),
    .halted    (halted)
  );

  // Clock / reset
  initial click = 1'b0;
  always #5 click = ~click;

  // Scoreboard state; vector = {state, halted, IRWre, PCWre, pc_src, RegWre, mem_rd, mem_wr}
  logic [10:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          check_en = 1'b0;
  logic [10:0] mon_exp;

  function automatic logic [10:0] observed();
    return {state, halted, IRWre, PCWre, pc_src, RegWre, mem_rd, mem_wr};
  endfunction

  function automatic void check(string name, logic [10:0] act, logic [10:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b, expected %b ({state,halted,IRWre,PCWre,pc_src,RegWre,mem_rd,mem_wr})",
               name, $time, act, exp);
    end
  endfunction

  // Monitor: one expected vector per clock, compared mid-cycle
  always @(negedge click) begin
    if (check_en) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL underflow at %0t: got %b, expected no cycle", $time, observed());
      end else begin
        mon_exp = exp_q.pop_front();
        check("cycle", observed(), mon_exp);
      end
    end
  end

  // Reference model: stage path of one instruction, then per-stage strobes.
  task automatic issue(input logic [5:0] op, input logic z, input int wait_cyc, input int halt_cyc);
    logic [2:0]  path[$];
    logic [10:0] v;
    bit is_alu, is_lw, is_sw, is_beq, is_j, is_halt, last, pcw;
    logic [1:0]  src;
    is_halt = (op == 6'b111111);
    is_alu  = (op == 6'b000000) || (op == 6'b000001);
    is_lw   = (op == 6'b110000);
    is_sw   = (op == 6'b110001);
    is_beq  = (op == 6'b110100);
    is_j    = (op == 6'b111000);
    path.push_back(3'b000);
    path.push_back(3'b001);
    if (is_halt) begin
      for (int i = 0; i < halt_cyc; i++) path.push_back(3'b111);
    end else if (is_alu || is_lw || is_sw || is_beq) begin
      path.push_back(3'b010);
      if (is_lw || is_sw) begin
        for (int i = 0; i <= wait_cyc; i++) path.push_back(3'b011);
      end
      if (is_alu || is_lw) path.push_back(3'b100);
    end
    for (int i = 0; i < path.size(); i++) begin
      last = (i == path.size() - 1);
      pcw  = last && !is_halt;
      src  = !pcw ? 2'b00 : is_j ? 2'b10 : (is_beq && z) ? 2'b01 : 2'b00;
      v = {path[i], path[i] == 3'b111, path[i] == 3'b000, pcw, src,
           path[i] == 3'b100, path[i] == 3'b011 && is_lw, path[i] == 3'b011 && is_sw};
      exp_q.push_back(v);
    end
    opcode = op;
    zero   = z;
    for (int c = 0; c < path.size(); c++) begin
      mem_ready = !(c >= 3 && c < 3 + wait_cyc);
      @(posedge click);
      #1;
    end
    mem_ready = 1'b1;
  endtask

  // Driver: hold reset low for n clock edges, expecting a quiet cycle each.
  task automatic do_reset(input int n);
    reset = 1'b0;
    for (int i = 0; i < n; i++) exp_q.push_back(11'b0);
    repeat (n) @(posedge click);
    #1;
    reset = 1'b1;
  endtask

  logic [5:0] rop;
  int         rsel;
  int         rwait;

  initial begin
    reset     = 1'b0;
    opcode    = 6'b0;
    zero      = 1'b0;
    mem_ready = 1'b1;
    exp_q.push_back(11'b0);
    exp_q.push_back(11'b0);
    check_en = 1'b1;
    repeat (3) @(posedge click);
    #1;
    reset = 1'b1;

    // Directed paths
    issue(6'b000000, 1'b0, 0, 0);
    issue(6'b000001, 1'b1, 0, 0);
    issue(6'b110000, 1'b0, 0, 0);
    issue(6'b110001, 1'b0, 0, 0);
    issue(6'b110100, 1'b1, 0, 0);
    issue(6'b110100, 1'b0, 0, 0);
    issue(6'b111000, 1'b0, 0, 0);
    issue(6'b101010, 1'b0, 0, 0);
`ifdef MEM_WAIT_EN
    issue(6'b110000, 1'b0, 3, 0);
    issue(6'b110001, 1'b0, 2, 0);
`endif

    // lw aborted by reset in the middle of EXE
    opcode = 6'b110000;
    zero   = 1'b0;
    exp_q.push_back(11'b000_0_1_0_00_0_0_0);
    exp_q.push_back(11'b001_0_0_0_00_0_0_0);
    exp_q.push_back(11'b010_0_0_0_00_0_0_0);
    repeat (2) @(posedge click);
    #1;
    @(negedge click);
    #2;
    reset = 1'b0;
    #1;
    check("reset_abort_now", observed(), 11'b0);
    exp_q.push_back(11'b0);
    repeat (2) @(posedge click);
    #1;
    reset = 1'b1;
    issue(6'b000000, 1'b0, 0, 0);

    // Randomized instruction stream
    for (int n = 0; n < 250; n++) begin
      rsel = $urandom_range(0, 7);
      case (rsel)
        0: rop = 6'b000000;
        1: rop = 6'b000001;
        2: rop = 6'b110000;
        3: rop = 6'b110001;
        4: rop = 6'b110100;
        5: rop = 6'b111000;
        default: rop = 6'($urandom_range(0, 62));
      endcase
`ifdef MEM_WAIT_EN
      rwait = $urandom_range(0, 3);
`else
      rwait = 0;
`endif
      issue(rop, 1'($urandom_range(0, 1)), rwait, 0);
    end

    // Halt is absorbing for 10 cycles, then reset recovers
    issue(6'b111111, 1'b0, 0, 10);
    do_reset(1);
    issue(6'b000000, 1'b1, 0, 0);
    issue(6'b111000, 1'b0, 0, 0);

    check_en = 1'b0;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: got %0d unconsumed cycles, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Time limit guard
  initial begin
    #200000;
    $display("FAIL timeout: got no completion, expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule
